// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester C/D handshakes plus the single-port data memory bus
interface dmem_arbiter_if #(parameter int Width = 32);
    logic             c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [Width-1:0] c_addr, c_wdata, c_rdata;
    logic             d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [Width-1:0] d_addr, d_wdata, d_rdata;
    logic             MemRead, MemWrite;
    logic [Width-1:0] mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output MemRead, MemWrite, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  MemRead, MemWrite, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority C/D arbiter with D starvation guard, one memory access per two cycles
module dmem_arbiter #(
    parameter int Width        = 32,
    parameter int DEPTH        = 512,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t           r_state;
    logic [3:0]       r_starve_cnt;
    logic             r_sel_d, r_we, r_in_range;
    logic [Width-1:0] r_addr, r_wdata;
    logic             r_c_gnt, r_d_gnt, r_c_rvalid, r_d_rvalid, r_c_err, r_d_err;
    logic [Width-1:0] r_c_rdata, r_d_rdata;
    logic             r_mem_read, r_mem_write;

    logic             w_d_win, w_we, w_in_range;
    logic [Width-1:0] w_addr, w_wdata;

    always_comb begin
        w_d_win    = bus.d_req && (!bus.c_req || r_starve_cnt == LIM);
        w_we       = w_d_win ? bus.d_we    : bus.c_we;
        w_addr     = w_d_win ? bus.d_addr  : bus.c_addr;
        w_wdata    = w_d_win ? bus.d_wdata : bus.c_wdata;
        w_in_range = w_addr < Width'(DEPTH);
    end

    // Strobes are decided at latch time so nothing from req reaches the memory combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_sel_d      <= 1'b0;
            r_we         <= 1'b0;
            r_in_range   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_c_gnt      <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_c_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_c_err      <= 1'b0;
            r_d_err      <= 1'b0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_c_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_c_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_c_err     <= 1'b0;
            r_d_err     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.c_req || bus.d_req) begin
                    r_state      <= ACCESS;
                    r_sel_d      <= w_d_win;
                    r_we         <= w_we;
                    r_addr       <= w_addr;
                    r_wdata      <= w_wdata;
                    r_in_range   <= w_in_range;
                    r_c_gnt      <= !w_d_win;
                    r_d_gnt      <= w_d_win;
                    r_mem_read   <= w_in_range && !w_we;
                    r_mem_write  <= w_in_range && w_we;
                    r_starve_cnt <= w_d_win ? 4'd0 :
                                    (bus.d_req && r_starve_cnt != LIM) ? r_starve_cnt + 4'd1 : r_starve_cnt;
                end
            end else begin
                r_state <= IDLE;
                if (r_sel_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_err    <= !r_in_range;
                    r_d_rdata  <= r_mem_read ? bus.mem_rdata : '0;
                end else begin
                    r_c_rvalid <= 1'b1;
                    r_c_err    <= !r_in_range;
                    r_c_rdata  <= r_mem_read ? bus.mem_rdata : '0;
                end
            end
        end
    end

    assign bus.c_gnt     = r_c_gnt;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.c_rvalid  = r_c_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.c_err     = r_c_err;
    assign bus.d_err     = r_d_err;
    assign bus.c_rdata   = r_c_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.MemRead   = r_mem_read;
    assign bus.MemWrite  = r_mem_write;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus directed sequences for starvation, reset abort and contention
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int viol = 0;
    logic [31:0] mem [512];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.Width(32)) bus ();
    dmem_arbiter #(.Width(32), .DEPTH(512), .STARVE_LIMIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always @(posedge clk) if (bus.MemWrite) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
    assign bus.mem_rdata = bus.MemRead ? mem[bus.mem_addr[8:0]] : 32'h0;

    always @(negedge clk)
        if (rst_n && ((bus.MemRead && bus.MemWrite) || (bus.c_gnt && bus.d_gnt))) viol++;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_mr;
        logic        exp_mw;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic is_d, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
        end
    endtask

    task automatic txn(input vec_t v, input string name);
        set_req(v.is_d, v.we, v.addr, v.wdata);
        tick;
        check({name, ".gnt"}, {30'd0, bus.d_gnt, bus.c_gnt}, v.is_d ? 32'd2 : 32'd1);
        check({name, ".MemRead"}, {31'd0, bus.MemRead}, {31'd0, v.exp_mr});
        check({name, ".MemWrite"}, {31'd0, bus.MemWrite}, {31'd0, v.exp_mw});
        check({name, ".mem_addr"}, bus.mem_addr, v.addr);
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        tick;
        check({name, ".rvalid"}, {30'd0, bus.d_rvalid, bus.c_rvalid}, v.is_d ? 32'd2 : 32'd1);
        check({name, ".rdata"}, v.is_d ? bus.d_rdata : bus.c_rdata, v.exp_rdata);
        check({name, ".err"}, {31'd0, v.is_d ? bus.d_err : bus.c_err}, {31'd0, v.exp_err});
        check({name, ".strobes_idle"}, {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    endtask

    initial begin
        logic [9:0] seq;
        int n;
        logic rv;
        vec_t v;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

        vecs[0] = '{1'b0, 1'b1, 32'd5,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'd5,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h1FF, 32'h12345678, 1'b0, 1'b1, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h1FF, 32'h0,        1'b1, 1'b0, 32'h12345678, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd88,  32'h00000055, 1'b0, 1'b1, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'd600, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'd600, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'd88,  32'h0,        1'b1, 1'b0, 32'h00000055, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'd512, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
        vecs[9] = '{1'b1, 1'b0, 32'd0,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0};

        #3;
        check("reset.outputs", {24'd0, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid,
                                bus.c_err, bus.d_err, bus.MemRead, bus.MemWrite}, 32'd0);
        check("reset.data", bus.c_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) txn(vecs[i], $sformatf("vec%0d", i));

        // Both requesters held: C wins four times, then the starvation guard hands one slot to D
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick;
        set_req(1'b0, 1'b0, 32'd5, 32'h0);
        set_req(1'b1, 1'b0, 32'h1FF, 32'h0);
        seq = '0;
        n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            tick;
            if (bus.c_gnt || bus.d_gnt) begin
                seq = {seq[8:0], bus.d_gnt};
                n++;
            end
        end
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        check("starve.count", n, 10);
        check("starve.order", {22'd0, seq}, {22'd0, 10'b0000100001});
        tick;
        tick;

        set_req(1'b0, 1'b1, 32'd7, 32'h77);
        tick;
        check("abort.MemWrite_before", {31'd0, bus.MemWrite}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort.MemWrite_drop", {30'd0, bus.MemWrite, bus.c_gnt}, 32'd0);
        bus.c_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        rv = 1'b0;
        repeat (4) begin
            tick;
            rv |= bus.c_rvalid;
        end
        check("abort.no_rvalid", {31'd0, rv}, 32'd0);
        v = '{1'b0, 1'b0, 32'd7, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
        txn(v, "abort.after");

        for (int k = 0; k < 2; k++) begin
            set_req(1'b0, 1'b0, 32'd5, 32'h0);
            set_req(1'b1, 1'b1, 32'd10 + k, 32'hC0DE0000 + k);
            tick;
            check($sformatf("both%0d.gnt1", k), {30'd0, bus.d_gnt, bus.c_gnt}, 32'd1);
            bus.c_req = 1'b0;
            tick;
            check($sformatf("both%0d.c_resp", k), {30'd0, bus.d_rvalid, bus.c_rvalid}, 32'd1);
            check($sformatf("both%0d.c_rdata", k), bus.c_rdata, 32'hDEADBEEF);
            check($sformatf("both%0d.d_wait", k), {31'd0, bus.d_gnt}, 32'd0);
            tick;
            check($sformatf("both%0d.gnt2", k), {30'd0, bus.d_gnt, bus.c_gnt}, 32'd2);
            check($sformatf("both%0d.no_c_rvalid", k), {31'd0, bus.c_rvalid}, 32'd0);
            bus.d_req = 1'b0;
            tick;
            check($sformatf("both%0d.d_resp", k), {30'd0, bus.d_rvalid, bus.c_rvalid}, 32'd2);
            check($sformatf("both%0d.d_err", k), {31'd0, bus.d_err}, 32'd0);
        end
        v = '{1'b0, 1'b0, 32'd10, 32'h0, 1'b1, 1'b0, 32'hC0DE0000, 1'b0};
        txn(v, "both.rd10");
        v = '{1'b0, 1'b0, 32'd11, 32'h0, 1'b1, 1'b0, 32'hC0DE0001, 1'b0};
        txn(v, "both.rd11");

        check("invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (MemRead/MemWrite/address/WriteData/ReadData interface).
- Requester C is the core load/store path; requester D is a DMA/debug port used for program loading and memory inspection.
- The block latches one request, drives exactly one memory access, and returns read data with a registered response pulse.
- Fixed-priority arbitration favours the core, with a starvation counter that guarantees D progress.

Parameters:
- Width, 32, data and address width.
- DEPTH, 512, number of memory words; valid word addresses are 0..DEPTH-1.
- STARVE_LIMIT, 4, number of consecutive D losses after which D wins the next arbitration; range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  core request; held with c_we/c_addr/c_wdata until c_gnt
- c_we  in  1  1=write, 0=read
- c_addr  in  Width  word address
- c_wdata  in  Width  write data
- c_gnt  out  1  one-cycle pulse, request accepted
- c_rvalid  out  1  one-cycle pulse, response (read data or error) valid
- c_rdata  out  Width  read data, valid with c_rvalid
- c_err  out  1  address out of range, valid with c_rvalid
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same as the c_* ports, for requester D
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- mem_addr  out  Width  memory address
- mem_wdata  out  Width  memory write data
- mem_rdata  in  Width  memory read data, combinational from mem_addr while MemRead=1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- On reset, and immediately on rst_n falling mid-operation:
  - state=IDLE, starve_cnt=0.
  - All gnt/rvalid/err/MemRead/MemWrite outputs are 0; all rdata, mem_addr and mem_wdata outputs are 0.
  - An in-flight access is abandoned with no response.
- State machine: IDLE and ACCESS.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise select a winner, latch its we/addr/wdata and its identity, and go to ACCESS.
- Winner selection:
  - D wins if d_req=1 and either c_req=0 or starve_cnt==STARVE_LIMIT.
  - Otherwise C wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when d_req=1 and C wins.
  - Clears when D wins.
  - Unchanged otherwise.
- ACCESS (exactly one cycle, then IDLE):
  - The winner's gnt=1 for this cycle.
  - mem_addr and mem_wdata come from the latched values.
  - If the latched addr < DEPTH: MemWrite=we and MemRead=~we.
  - If the latched addr >= DEPTH: MemRead=MemWrite=0, with no memory side effect.
- Response, in the cycle after ACCESS:
  - The winner's rvalid=1 for one cycle, for both reads and writes.
  - rdata = mem_rdata sampled at the end of ACCESS for an in-range read, otherwise 0.
  - err=1 only for out-of-range addresses.
- Throughput and latency:
  - Peak throughput is one access per 2 cycles.
  - Latency from sampling req in IDLE is 1 cycle to gnt and 2 cycles to rvalid.
  - A response pulse may coincide with the next IDLE arbitration.
- Request hold rule:
  - Requesters must hold req and payload stable until gnt.
  - A req deasserted before gnt is simply not served.
  - Requests arriving during ACCESS are evaluated in the next IDLE.
- Output guarantees:
  - MemRead and MemWrite are never both 1.
  - MemRead and MemWrite are 0 in IDLE.
  - c_gnt and d_gnt are never both 1.
- Outputs are registered or derived only from state and latched values; no combinational path from the req inputs to the memory strobes.

Test Plan:
- Reset, then C write addr=5 data=0xDEADBEEF, then C read addr=5 -> MemWrite high for exactly 1 cycle; c_rvalid 2 cycles after sampling; c_rdata=0xDEADBEEF; c_err=0.
- c_req and d_req held high continuously with STARVE_LIMIT=4 -> grant order is C,C,C,C,D repeating; d_gnt is never delayed more than 5 grants.
- D read addr=600 (>=DEPTH) -> MemRead=0 throughout; d_rvalid=1, d_err=1, d_rdata=0; memory contents unchanged.
- Only d_req, read addr=0x1FF -> D granted in the first ACCESS; starve_cnt stays 0; d_rdata equals the stored word.
- rst_n asserted low during ACCESS of a C write -> MemWrite drops immediately; no c_rvalid follows; the next request after reset is served normally.
- C read and D write issued in the same cycle, then repeated -> C is served first each time; the response pulses never overlap; the data returned to each requester is correct.
